ram_sp_ctrl: RTL and testbench

- Parametrised single-port synchronous RAM with a valid/ready request and response handshake, per-byte write enables and a hardware clear sequencer.
- Successor to the fixed 128x32 word store. It sits between the UART command decoder and the AES data/key path as the scratch buffer.
- After reset, or on request, it sweeps the whole array to CLEAR_VAL before accepting traffic.

---
 rtl/ram_sp_ctrl_pkg.sv | 24 ++
 rtl/ram_sp_array.sv | 79 +++++++
 rtl/ram_sp_ctrl.sv | 114 +++++++++++
 tb/tb_ram_sp_ctrl.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/ram_sp_ctrl_pkg.sv
// rtl/ram_sp_ctrl_pkg.sv - shared types and helpers for the single-port RAM controller
package ram_sp_ctrl_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    // Widest data word the parity helper accepts; callers zero-extend into it.
    localparam int PAR_MAX_W = 1024;

    function automatic int be_width(input int data_w);
        return data_w / 8;
    endfunction

    function automatic logic [PAR_MAX_W/8-1:0] byte_parity(input logic [PAR_MAX_W-1:0] data);
        logic [PAR_MAX_W/8-1:0] p;
        for (int i = 0; i < PAR_MAX_W / 8; i++) begin
            p[i] = ^data[8*i +: 8];
        end
        return p;
    endfunction

endpackage

// File: rtl/ram_sp_array.sv
// rtl/ram_sp_array.sv - byte-enabled storage array with registered read port
// Optional per-byte even parity storage under RAM_SP_CTRL_PARITY_EN.
module ram_sp_array
    import ram_sp_ctrl_pkg::*;
#(
    parameter int                DATA_W    = 32,
    parameter int                ADDR_W    = 7,
    parameter int                DEPTH     = 2**ADDR_W,
    parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic                     re,
    input  logic [ADDR_W-1:0]        addr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic [be_width(DATA_W)-1:0] be,
    output logic [DATA_W-1:0]        rdata,
    output logic                     rperr
);
    localparam int BE_W = be_width(DATA_W);

    logic [DATA_W-1:0] mem [0:DEPTH-1];
    logic              in_range;

    assign in_range = (int'(addr) < DEPTH);

    always_ff @(posedge clk) begin
        if (we && in_range) begin
            for (int i = 0; i < BE_W; i++) begin
                if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= in_range ? mem[addr] : CLEAR_VAL;
        end
    end

`ifdef RAM_SP_CTRL_PARITY_EN
    function automatic logic [BE_W-1:0] par_of(input logic [DATA_W-1:0] d);
        logic [PAR_MAX_W-1:0]   ext;
        logic [PAR_MAX_W/8-1:0] p;
        ext = '0;
        ext[DATA_W-1:0] = d;
        p = byte_parity(ext);
        return p[BE_W-1:0];
    endfunction

    logic [BE_W-1:0] par [0:DEPTH-1];
    logic [BE_W-1:0] wpar;

    assign wpar = par_of(wdata);

    always_ff @(posedge clk) begin
        if (we && in_range) begin
            for (int i = 0; i < BE_W; i++) begin
                if (be[i]) par[addr][i] <= wpar[i];
            end
        end
    end

    // Error flag is captured alongside rdata so both hold together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rperr <= 1'b0;
        end else if (re) begin
            rperr <= in_range ? |(par_of(mem[addr]) ^ par[addr]) : 1'b0;
        end
    end
`else
    assign rperr = 1'b0;
`endif

endmodule

// File: rtl/ram_sp_ctrl.sv
// rtl/ram_sp_ctrl.sv - single-port RAM with valid/ready handshake and clear sequencer
// Optional parity checking under RAM_SP_CTRL_PARITY_EN.
module ram_sp_ctrl
    import ram_sp_ctrl_pkg::*;
#(
    parameter int                DATA_W    = 32,
    parameter int                ADDR_W    = 7,
    parameter int                DEPTH     = 2**ADDR_W,
    parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic                        req_we,
    input  logic [ADDR_W-1:0]           req_addr,
    input  logic [DATA_W-1:0]           req_wdata,
    input  logic [be_width(DATA_W)-1:0] req_be,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [DATA_W-1:0]           rsp_rdata,
    output logic                        rsp_perr,
    input  logic                        clear_start,
    output logic                        busy
);
    localparam int              BE_W = be_width(DATA_W);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] cnt, cnt_nxt;
    logic              arr_we, arr_re;
    logic [ADDR_W-1:0] arr_addr;
    logic [DATA_W-1:0] arr_wdata;
    logic [BE_W-1:0]   arr_be;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_CLEAR;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        busy      = 1'b0;
        req_ready = 1'b0;
        arr_we    = 1'b0;
        arr_re    = 1'b0;
        arr_addr  = req_addr;
        arr_wdata = req_wdata;
        arr_be    = req_be;
        case (state)
            ST_CLEAR: begin
                busy      = 1'b1;
                arr_we    = 1'b1;
                arr_addr  = cnt;
                arr_wdata = CLEAR_VAL;
                arr_be    = '1;
                if (cnt == LAST) begin
                    state_nxt = ST_RUN;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + ADDR_W'(1);
                end
            end
            ST_RUN: begin
                // A pending response blocks new requests until it is consumed.
                req_ready = !clear_start && (!rsp_valid || rsp_ready);
                arr_we    = req_valid && req_ready && req_we;
                arr_re    = req_valid && req_ready && !req_we;
                if (clear_start) begin
                    state_nxt = ST_CLEAR;
                    cnt_nxt   = '0;
                end
            end
            default: begin
                state_nxt = ST_CLEAR;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid <= 1'b0;
        end else if (arr_re) begin
            rsp_valid <= 1'b1;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

    ram_sp_array #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .DEPTH     (DEPTH),
        .CLEAR_VAL (CLEAR_VAL)
    ) u_array (
        .clk   (clk),
        .rst   (rst),
        .we    (arr_we),
        .re    (arr_re),
        .addr  (arr_addr),
        .wdata (arr_wdata),
        .be    (arr_be),
        .rdata (rsp_rdata),
        .rperr (rsp_perr)
    );

endmodule

// File: tb/tb_ram_sp_ctrl.sv
// tb/tb_ram_sp_ctrl.sv - directed self-checking bench for ram_sp_ctrl
module tb_ram_sp_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [6:0]  req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_be = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_rdata;
    logic        rsp_perr;
    logic        clear_start = 1'b0;
    logic        busy;

    int vectors = 0;
    int miscompares = 0;
    int n;

    always #5 clk = ~clk;

    ram_sp_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_be      (req_be),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_perr    (rsp_perr),
        .clear_start (clear_start),
        .busy        (busy)
    );

    task automatic check_vec(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [6:0] a, input logic [31:0] d, input logic [3:0] be);
        req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d; req_be = be;
        tick();
        req_valid = 1'b0; req_we = 1'b0;
    endtask

    task automatic do_read(input logic [6:0] a);
        req_valid = 1'b1; req_we = 1'b0; req_addr = a;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic sweep_len(output int cycles, input bit poke);
        cycles = 0;
        while (busy && cycles < 1000) begin
            clear_start = (poke && cycles == 10);
            tick();
            cycles++;
        end
        clear_start = 1'b0;
    endtask

    initial begin
        #2;
        check_vec("rst_req_ready", req_ready, 0);
        check_vec("rst_rsp_valid", rsp_valid, 0);
        check_vec("rst_rsp_rdata", rsp_rdata, 0);
        check_vec("rst_rsp_perr", rsp_perr, 0);
        check_vec("rst_busy", busy, 1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // 1: initial sweep, then read the top word
        sweep_len(n, 1'b0);
        check_vec("sweep1_len", n, 128);
        check_vec("run_busy", busy, 0);
        check_vec("run_ready", req_ready, 1);
        do_read(7'h7F);
        check_vec("rd7f_valid", rsp_valid, 1);
        check_vec("rd7f_data", rsp_rdata, 32'h0);
        check_vec("rd7f_perr", rsp_perr, 0);

        // 2: byte-enable merge, read right after write
        do_write(7'd5, 32'hDEADBEEF, 4'hF);
        do_write(7'd5, 32'h11223344, 4'b0101);
        do_read(7'd5);
        check_vec("be_merge_valid", rsp_valid, 1);
        check_vec("be_merge_data", rsp_rdata, 32'hDE22BE44);
        tick();
        check_vec("rsp_drop", rsp_valid, 0);

        // 3: backpressure hold
        rsp_ready = 1'b0;
        do_read(7'd5);
        for (int i = 0; i < 10; i++) begin
            check_vec("hold_data", rsp_rdata, 32'hDE22BE44);
            check_vec("hold_ready", req_ready, 0);
            check_vec("hold_valid", rsp_valid, 1);
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        check_vec("release_ready_comb", req_ready, 1);
        tick();
        check_vec("release_valid", rsp_valid, 0);
        check_vec("release_ready", req_ready, 1);
        check_vec("release_data_kept", rsp_rdata, 32'hDE22BE44);

        // 4: back-to-back reads
        do_write(7'd1, 32'hA1A1A1A1, 4'hF);
        do_write(7'd2, 32'hB2B2B2B2, 4'hF);
        do_write(7'd3, 32'hC3C3C3C3, 4'hF);
        req_valid = 1'b1; req_we = 1'b0;
        req_addr = 7'd1; tick();
        check_vec("stream1_valid", rsp_valid, 1);
        check_vec("stream1_data", rsp_rdata, 32'hA1A1A1A1);
        req_addr = 7'd2; tick();
        check_vec("stream2_valid", rsp_valid, 1);
        check_vec("stream2_data", rsp_rdata, 32'hB2B2B2B2);
        req_addr = 7'd3; tick();
        check_vec("stream3_valid", rsp_valid, 1);
        check_vec("stream3_data", rsp_rdata, 32'hC3C3C3C3);
        req_valid = 1'b0; tick();
        check_vec("stream_end_valid", rsp_valid, 0);

        // 5: clear with a pending response; clear_start mid-sweep is ignored
        rsp_ready = 1'b0;
        do_read(7'd5);
        clear_start = 1'b1;
        #1;
        check_vec("clr_blocks_ready", req_ready, 0);
        tick();
        clear_start = 1'b0;
        check_vec("clr_busy", busy, 1);
        sweep_len(n, 1'b1);
        check_vec("sweep2_len", n, 128);
        check_vec("clr_pending_valid", rsp_valid, 1);
        check_vec("clr_pending_data", rsp_rdata, 32'hDE22BE44);
        rsp_ready = 1'b1;
        tick();
        do_read(7'd5);
        check_vec("cleared_valid", rsp_valid, 1);
        check_vec("cleared_data", rsp_rdata, 32'h0);
        tick();

        // 6: reset mid-sweep with a pending response
        rsp_ready = 1'b0;
        do_write(7'd1, 32'h12345678, 4'hF);
        do_read(7'd1);
        check_vec("pre_rst_data", rsp_rdata, 32'h12345678);
        clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
        for (int i = 0; i < 60; i++) tick();
        check_vec("pre_rst_valid", rsp_valid, 1);
        rst = 1'b1;
        #1;
        check_vec("midrst_valid", rsp_valid, 0);
        check_vec("midrst_busy", busy, 1);
        check_vec("midrst_data", rsp_rdata, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        rsp_ready = 1'b1;
        sweep_len(n, 1'b0);
        check_vec("sweep3_len", n, 128);
        do_read(7'd1);
        check_vec("post_rst_data", rsp_rdata, 32'h0);
        tick();

`ifdef RAM_SP_CTRL_PARITY_EN
        do_write(7'd9, 32'h0F0F0F0F, 4'hF);
        do_read(7'd9);
        check_vec("par_clean", rsp_perr, 0);
        tick();
        dut.u_array.mem[9][0] = ~dut.u_array.mem[9][0];
        do_read(7'd9);
        check_vec("par_err_valid", rsp_valid, 1);
        check_vec("par_err", rsp_perr, 1);
        do_read(7'd3);
        check_vec("par_other", rsp_perr, 0);
        tick();
`else
        do_write(7'd9, 32'h0F0F0F0F, 4'hF);
        do_read(7'd9);
        check_vec("noparity_data", rsp_rdata, 32'h0F0F0F0F);
        check_vec("noparity_perr", rsp_perr, 0);
        tick();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
